// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, buffers words in a 2-entry FIFO.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a trap entry (if_misalign_o) and halts fetch.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic            if_misalign_o,
`endif
   output logic [31:0]     if_instr_o
);

   localparam logic [31:0]     NOP        = 32'h0000_0013;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   typedef enum logic [1:0] {BOOT, REQ, FULL, HALT} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic            req_q;
   logic [XLEN-1:0] fifo_pc    [2];
   logic [31:0]     fifo_instr [2];
`ifdef FETCH_MISALIGN_TRAP_EN
   logic            fifo_mis   [2];
`endif
   logic            rd_ptr;
   logic            wr_ptr;
   logic [1:0]      count;
   logic [1:0]      count_nxt;
   logic            valid;
   logic            push;
   logic            pop;

   assign valid = (count != 2'd0);
   assign push  = (state == REQ) && imem_ack_i;
   assign pop   = valid && !stall_i;

   always_comb begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
   end

   // Redirect overrides everything: flush, realign the PC and discard any ack seen this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= BOOT;
         pc     <= RESET_PC;
         req_q  <= 1'b0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            fifo_mis[i]   <= 1'b0;
`endif
         end
      end else if (redirect_i) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         pc     <= redirect_pc_i & ALIGN_MASK;
         state  <= REQ;
         req_q  <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_pc_i[1:0] != 2'b00) begin
            fifo_pc[0]    <= redirect_pc_i;
            fifo_instr[0] <= 32'h0000_0000;
            fifo_mis[0]   <= 1'b1;
            wr_ptr        <= 1'b1;
            count         <= 2'd1;
            state         <= HALT;
            req_q         <= 1'b0;
         end
`endif
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_rdata_i;
`ifdef FETCH_MISALIGN_TRAP_EN
            fifo_mis[wr_ptr]   <= 1'b0;
`endif
            wr_ptr             <= ~wr_ptr;
            pc                 <= pc + PC_STEP;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_nxt;
         case (state)
            BOOT: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (push && count_nxt == 2'd2) begin
                  state <= FULL;
                  req_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            default: begin
               state <= HALT;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc;
   assign if_valid_o  = valid;
   assign if_pc_o     = valid ? fifo_pc[rd_ptr] : '0;
   assign if_instr_o  = valid ? fifo_instr[rd_ptr] : NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign if_misalign_o = valid && fifo_mis[rd_ptr];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: zero-wait, stall, slow memory, redirect, wrap, misalign, reset.
// Optional macro FETCH_MISALIGN_TRAP_EN selects the trap expectations for misaligned redirects.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_misalign_o;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .reset(reset),
      .stall_i(stall_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i),
      .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o),
      .if_pc_o(if_pc_o),
`ifdef FETCH_MISALIGN_TRAP_EN
      .if_misalign_o(if_misalign_o),
`endif
      .if_instr_o(if_instr_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   // Inputs change at the negedge; registered DUT outputs are stable there, so the memory answers combinationally.
   task automatic drive(input logic mem_ok, input logic stall);
      stall_i      = stall;
      imem_ack_i   = mem_ok && imem_req_o;
      imem_rdata_i = word_of(imem_addr_o);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      repeat (2) @(negedge clk);
      checks += 5;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got %b exp 0", imem_req_o); end
      if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got %h exp 0", imem_addr_o); end
      if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b exp 0", if_valid_o); end
      if (if_pc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h exp 0", if_pc_o); end
      if (if_instr_o !== NOP) begin failures++; $display("[TB] FAIL reset_instr got %h exp %h", if_instr_o, NOP); end
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL boot_req got %b exp 0", imem_req_o); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_pc;
      do_reset();
      drive(1'b1, 1'b0); tick();
      for (int c = 1; c <= 6; c++) begin
         exp_pc = 32'(4 * (c - 2));
         checks += 2;
         if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL zw_req c%0d got %b exp 1", c, imem_req_o); end
         if (imem_addr_o !== 32'(4 * (c - 1))) begin failures++; $display("[TB] FAIL zw_addr c%0d got %h exp %h", c, imem_addr_o, 32'(4 * (c - 1))); end
         checks++;
         if (if_valid_o !== (c >= 2)) begin failures++; $display("[TB] FAIL zw_valid c%0d got %b exp %b", c, if_valid_o, (c >= 2)); end
         if (c >= 2) begin
            checks += 2;
            if (if_pc_o !== exp_pc) begin failures++; $display("[TB] FAIL zw_pc c%0d got %h exp %h", c, if_pc_o, exp_pc); end
            if (if_instr_o !== word_of(exp_pc)) begin failures++; $display("[TB] FAIL zw_instr c%0d got %h exp %h", c, if_instr_o, word_of(exp_pc)); end
         end
         drive(1'b1, 1'b0); tick();
      end
   endtask

   task automatic test_stall();
      logic [31:0] drain [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      drive(1'b1, 1'b1); tick();
      for (int c = 1; c <= 5; c++) begin
         if (c >= 3) begin
            checks += 3;
            if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_req c%0d got %b exp 0", c, imem_req_o); end
            if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid c%0d got %b exp 1", c, if_valid_o); end
            if (if_pc_o !== 32'h0) begin failures++; $display("[TB] FAIL stall_pc c%0d got %h exp 0", c, if_pc_o); end
         end
         drive(1'b1, 1'b1); tick();
      end
      checks++;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_rel_req got %b exp 0", imem_req_o); end
      for (int k = 0; k < 4; k++) begin
         checks += 2;
         if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL drain_valid k%0d got %b exp 1", k, if_valid_o); end
         if (if_pc_o !== drain[k]) begin failures++; $display("[TB] FAIL drain_pc k%0d got %h exp %h", k, if_pc_o, drain[k]); end
         drive(1'b1, 1'b0); tick();
      end
   endtask

   task automatic test_slow_mem();
      do_reset();
      drive(1'b0, 1'b0); tick();
      for (int c = 1; c <= 10; c++) begin
         checks += 2;
         if (imem_addr_o !== 32'(4 * ((c - 1) / 3))) begin failures++; $display("[TB] FAIL slow_addr c%0d got %h exp %h", c, imem_addr_o, 32'(4 * ((c - 1) / 3))); end
         if (if_valid_o !== (c >= 4 && c % 3 == 1)) begin failures++; $display("[TB] FAIL slow_valid c%0d got %b exp %b", c, if_valid_o, (c >= 4 && c % 3 == 1)); end
         if (c >= 4 && c % 3 == 1) begin
            checks++;
            if (if_pc_o !== 32'(4 * ((c - 4) / 3))) begin failures++; $display("[TB] FAIL slow_pc c%0d got %h exp %h", c, if_pc_o, 32'(4 * ((c - 4) / 3))); end
         end
         drive(c % 3 == 0, 1'b0); tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      repeat (3) begin drive(1'b1, 1'b0); tick(); end
      checks++;
      if (imem_addr_o !== 32'h8) begin failures++; $display("[TB] FAIL redir_pre_addr got %h exp 8", imem_addr_o); end
      drive(1'b1, 1'b0);
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      tick();
      redirect_i = 1'b0;
      checks += 3;
      if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL redir_valid got %b exp 0", if_valid_o); end
      if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL redir_req got %b exp 1", imem_req_o); end
      if (imem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL redir_addr got %h exp 100", imem_addr_o); end
      drive(1'b1, 1'b0); tick();
      checks += 2;
      if (if_pc_o !== 32'h100) begin failures++; $display("[TB] FAIL redir_pc0 got %h exp 100", if_pc_o); end
      if (if_instr_o !== word_of(32'h100)) begin failures++; $display("[TB] FAIL redir_instr got %h exp %h", if_instr_o, word_of(32'h100)); end
      drive(1'b1, 1'b0); tick();
      checks++;
      if (if_pc_o !== 32'h104) begin failures++; $display("[TB] FAIL redir_pc1 got %h exp 104", if_pc_o); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      drive(1'b1, 1'b0); tick();
      drive(1'b1, 1'b0);
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_i = 1'b0;
      checks++;
      if (imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_addr0 got %h exp fffffffc", imem_addr_o); end
      drive(1'b1, 1'b0); tick();
      checks += 2;
      if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr1 got %h exp 0", imem_addr_o); end
      if (if_pc_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pc got %h exp fffffffc", if_pc_o); end
   endtask

   task automatic test_misalign();
      do_reset();
      repeat (3) begin drive(1'b1, 1'b0); tick(); end
      drive(1'b1, 1'b0);
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      tick();
      redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      checks += 5;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_req got %b exp 0", imem_req_o); end
      if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL mis_valid got %b exp 1", if_valid_o); end
      if (if_misalign_o !== 1'b1) begin failures++; $display("[TB] FAIL mis_flag got %b exp 1", if_misalign_o); end
      if (if_pc_o !== 32'h102) begin failures++; $display("[TB] FAIL mis_pc got %h exp 102", if_pc_o); end
      if (if_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL mis_instr got %h exp 0", if_instr_o); end
      drive(1'b1, 1'b0); tick();
      checks += 2;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_halt_req got %b exp 0", imem_req_o); end
      if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_halt_valid got %b exp 0", if_valid_o); end
`else
      checks += 2;
      if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL mis_req got %b exp 1", imem_req_o); end
      if (imem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL mis_addr got %h exp 100", imem_addr_o); end
      drive(1'b1, 1'b0); tick();
      checks++;
      if (if_pc_o !== 32'h100) begin failures++; $display("[TB] FAIL mis_pc got %h exp 100", if_pc_o); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (3) begin drive(1'b1, 1'b0); tick(); end
      drive(1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checks += 5;
      if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_req got %b exp 0", imem_req_o); end
      if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL mid_addr got %h exp 0", imem_addr_o); end
      if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got %b exp 0", if_valid_o); end
      if (if_pc_o !== 32'h0) begin failures++; $display("[TB] FAIL mid_pc got %h exp 0", if_pc_o); end
      if (if_instr_o !== NOP) begin failures++; $display("[TB] FAIL mid_instr got %h exp %h", if_instr_o, NOP); end
      @(negedge clk);
      do_reset();
      drive(1'b1, 1'b0); tick();
      checks += 2;
      if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_rel_req got %b exp 1", imem_req_o); end
      if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL mid_rel_addr got %h exp 0", imem_addr_o); end
      drive(1'b1, 1'b0); tick();
      checks++;
      if (if_pc_o !== 32'h0 || if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_rel_pc got %h/%b exp 0/1", if_pc_o, if_valid_o); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_slow_mem();
      test_redirect();
      test_pc_wrap();
      test_misalign();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
